// File: rtl/keypad_encoder.sv
// keypad_encoder: debounces buttons A/B/C into one-cycle 2-bit key codes; KEY_COUNT_EN adds a 3-bit key_count output
module keypad_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
`ifdef KEY_COUNT_EN
  output logic [2:0] key_count,
`endif
  output logic [1:0] digito
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
  state_t state, state_n;
  logic [2:0] meta, s, key, key_n;
  logic [CW-1:0] count, count_n;
  logic [1:0] digito_n;
  logic one_hot;
  assign one_hot = (s != 3'b000) && ((s & (s - 3'd1)) == 3'b000);
  // next-state: a press needs a stable one-hot run, a release a stable all-zero run
  always_comb begin
    state_n  = state;
    count_n  = count;
    key_n    = key;
    digito_n = 2'b00;
    unique case (state)
      IDLE:
        if (one_hot) begin
          key_n   = s;
          count_n = '0;
          state_n = PRESS_DB;
        end else if (s != 3'b000) state_n = HELD;
      PRESS_DB:
        if (s != key) state_n = IDLE;
        else if (count == LAST) begin
          digito_n = {key[2] | key[1], key[2] | key[0]};
          state_n  = HELD;
        end else count_n = count + ONE;
      HELD:
        if (s == 3'b000) begin
          count_n = '0;
          state_n = RELEASE_DB;
        end
      RELEASE_DB:
        if (s != 3'b000) state_n = HELD;
        else if (count == LAST) state_n = IDLE;
        else count_n = count + ONE;
      default: state_n = HELD;
    endcase
  end
  // synchronizers, FSM state and the registered single-cycle code; reset parks in HELD so held keys are ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta   <= 3'b000;
      s      <= 3'b000;
      state  <= HELD;
      count  <= '0;
      key    <= 3'b000;
      digito <= 2'b00;
    end else begin
      meta   <= {btn_c, btn_b, btn_a};
      s      <= meta;
      state  <= state_n;
      count  <= count_n;
      key    <= key_n;
      digito <= digito_n;
    end
  end
`ifdef KEY_COUNT_EN
  // counts emitted codes, wrapping 7->0
  always_ff @(posedge clk) begin
    if (!reset) key_count <= 3'd0;
    else if (digito_n != 2'b00) key_count <= key_count + 3'd1;
  end
`endif
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: table vectors, corner sequences and random stimulus against a run-length reference model
module tb_keypad_encoder;
  localparam int D = 4;
  logic clk = 1'b0, reset = 1'b0, btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
  logic [1:0] digito;
`ifdef KEY_COUNT_EN
  logic [2:0] key_count;
`endif
  int checks = 0, errors = 0;
  keypad_encoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
`ifdef KEY_COUNT_EN
    .key_count(key_count),
`endif
    .digito(digito));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] btn;
    int cyc;
    logic rn;
    int pulses;
    int code;
    int at;
  } row_t;
  logic [2:0] p1 = 3'b000, p2 = 3'b000;
  bit armed = 1'b0;
  int cand = 0, run = 0, zrun = 0, kc = 0;
  logic [1:0] exp_d = 2'b00;
  int npulse, first_at, last_code, idx;
  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask
  function automatic int code_of(input logic [2:0] v);
    return v == 3'b001 ? 1 : v == 3'b010 ? 2 : v == 3'b100 ? 3 : 0;
  endfunction
  // a press counts after D+1 equal one-hot samples starting while armed; re-arming needs D+1 zero samples
  task automatic model_edge();
    logic [2:0] v;
    exp_d = 2'b00;
    if (!reset) begin
      p1 = 3'b000; p2 = 3'b000; armed = 1'b0; cand = 0; run = 0; zrun = 0; kc = 0;
    end else begin
      v = p2; p2 = p1; p1 = {btn_c, btn_b, btn_a};
      if (!armed) begin
        zrun = (v == 3'b000) ? zrun + 1 : 0;
        if (zrun == D + 1) begin armed = 1'b1; zrun = 0; end
      end else if (cand == 0) begin
        if (code_of(v) != 0) begin cand = code_of(v); run = 1; end
        else if (v != 3'b000) begin armed = 1'b0; zrun = 0; end
      end else if (code_of(v) == cand) begin
        run++;
        if (run == D + 1) begin
          exp_d = 2'(cand); kc = (kc + 1) % 8; armed = 1'b0; cand = 0; zrun = 0;
        end
      end else cand = 0;
    end
  endtask
  task automatic tick(input logic [2:0] b, input logic rn);
    {btn_c, btn_b, btn_a} = b;
    reset = rn;
    @(posedge clk);
    model_edge();
    #1;
    check("digito", int'(digito), int'(exp_d));
`ifdef KEY_COUNT_EN
    check("key_count", int'(key_count), kc);
`endif
    if (digito != 2'b00) begin
      if (npulse == 0) first_at = idx;
      npulse++;
      last_code = int'(digito);
    end
    idx++;
  endtask
  task automatic start_seq();
    npulse = 0; first_at = -1; last_code = 0; idx = 0;
  endtask
  initial begin
    row_t rows[$];
    rows.push_back('{3'b000, 2, 1'b0, 0, 0, -1});
    rows.push_back('{3'b000, 30, 1'b1, 0, 0, -1});
    rows.push_back('{3'b100, 20, 1'b1, 1, 3, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b010, 2, 1'b1, 0, 0, -1});
    rows.push_back('{3'b000, 2, 1'b1, 0, 0, -1});
    rows.push_back('{3'b010, 2, 1'b1, 0, 0, -1});
    rows.push_back('{3'b000, 2, 1'b1, 0, 0, -1});
    rows.push_back('{3'b010, 15, 1'b1, 1, 2, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b011, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b001, 10, 1'b1, 1, 1, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b000, 2, 1'b0, 0, 0, -1});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b100, 10, 1'b1, 1, 3, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b010, 10, 1'b1, 1, 2, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b001, 10, 1'b1, 1, 1, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b010, 10, 1'b1, 1, 2, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    rows.push_back('{3'b100, 10, 1'b1, 1, 3, 6});
    rows.push_back('{3'b000, 10, 1'b1, 0, 0, -1});
    foreach (rows[r]) begin
      start_seq();
      for (int k = 0; k < rows[r].cyc; k++) tick(rows[r].btn, rows[r].rn);
      check($sformatf("row%0d_pulses", r), npulse, rows[r].pulses);
      if (rows[r].pulses > 0) begin
        check($sformatf("row%0d_code", r), last_code, rows[r].code);
        check($sformatf("row%0d_at", r), first_at, rows[r].at);
      end
    end
`ifdef KEY_COUNT_EN
    check("password_key_count", int'(key_count), 5);
`endif
    start_seq();
    for (int k = 0; k < 3; k++) tick(3'b001, 1'b1);
    tick(3'b001, 1'b0);
    for (int k = 0; k < 20; k++) tick(3'b001, 1'b1);
    check("held_through_reset_pulses", npulse, 0);
    start_seq();
    for (int k = 0; k < 8; k++) tick(3'b000, 1'b1);
    for (int k = 0; k < 10; k++) tick(3'b001, 1'b1);
    check("repress_pulses", npulse, 1);
    check("repress_code", last_code, 1);
    check("repress_at", first_at, 14);
    for (int n = 0; n < 80; n++) begin
      logic [2:0] b;
      int r, len;
      r = $urandom_range(0, 9);
      len = $urandom_range(1, 12);
      b = r < 4 ? 3'b000 : r < 9 ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      for (int k = 0; k < len; k++) tick(b, $urandom_range(0, 149) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
